gpu_dmem_arbiter: RTL

Shares one single-port synchronous data RAM between the NUM_CHANNELS GPU LSU data-memory channels and one host (PCIe-side) port. Each requester uses a 4-phase valid/ready handshake. Accesses are serialized in grant order, one issue per cycle, using round-robin between channels and alternating priority for the host. The block sits between the GPU core's data-memory bus and the data RAM inside the GPU memory subsystem.

---
 rtl/gpu_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/gpu_dmem_arbiter.sv
// gpu_dmem_arbiter: serializes NUM_CHANNELS GPU LSU data-memory channels plus one
// host port onto a single-port synchronous data RAM. Host alternates with channels,
// channels are served round-robin, and the RAM sees at most one access per cycle.
module gpu_dmem_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_BITS    = 12,
    parameter int DATA_BITS    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           ch_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_read_address,
    output logic [NUM_CHANNELS-1:0]           ch_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] ch_read_data,
    input  logic [NUM_CHANNELS-1:0]           ch_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_write_data,
    output logic [NUM_CHANNELS-1:0]           ch_write_ready,
    input  logic                              host_req,
    input  logic                              host_we,
    input  logic [ADDR_BITS-1:0]              host_addr,
    input  logic [DATA_BITS-1:0]              host_wdata,
    output logic                              host_ack,
    output logic [DATA_BITS-1:0]              host_rdata,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [ADDR_BITS-1:0]              mem_addr,
    output logic [DATA_BITS-1:0]              mem_wdata,
    input  logic [DATA_BITS-1:0]              mem_rdata,
    output logic                              busy
);

    localparam int NUM_REQ = NUM_CHANNELS + 1;
    localparam int HOST_ID = NUM_CHANNELS;
    localparam int PTR_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int ID_W    = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_PENDING,
        REQ_DONE
    } req_state_e;

    // One entry of the in-flight pipeline: who was granted and what kind of access.
    typedef struct packed {
        logic            valid;
        logic            is_write;
        logic [ID_W-1:0] id;
    } inflight_t;

    // Per-requester state; entries 0..NUM_CHANNELS-1 are channels, HOST_ID is the host.
    req_state_e           state_q [NUM_REQ];
    req_state_e           state_d [NUM_REQ];
    logic                 we_q    [NUM_REQ];
    logic                 we_d    [NUM_REQ];
    logic [DATA_BITS-1:0] rdata_q [NUM_REQ];
    logic                 req_hold [NUM_REQ];

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 last_host_q, last_host_d;
    inflight_t            s1_q, s1_d, s2_q;

    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;

    logic [NUM_CHANNELS-1:0] ch_elig;
    logic                    host_elig;
    logic                    ch_found;
    logic [PTR_W-1:0]        ch_pick;
    logic                    grant_valid;
    logic                    grant_host;
    logic                    grant_we;
    logic [ID_W-1:0]         grant_id;
    logic [ADDR_BITS-1:0]    grant_addr;
    logic [DATA_BITS-1:0]    grant_wdata;

    // Eligibility and the "still holding its request" view used to leave DONE.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_elig[i]  = (state_q[i] == REQ_IDLE) && (ch_read_valid[i] || ch_write_valid[i]);
            req_hold[i] = we_q[i] ? ch_write_valid[i] : ch_read_valid[i];
        end
        host_elig         = (state_q[HOST_ID] == REQ_IDLE) && host_req;
        req_hold[HOST_ID] = host_req;
    end

    // Winner selection: host if it did not win last time, else round-robin channel, else host.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        ch_found    = 1'b0;
        ch_pick     = '0;
        grant_valid = 1'b0;
        grant_host  = 1'b0;
        grant_we    = 1'b0;
        grant_id    = '0;
        grant_addr  = '0;
        grant_wdata = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            if (!ch_found && ch_elig[(int'(rr_ptr_q) + k) % NUM_CHANNELS]) begin
                ch_found = 1'b1;
                ch_pick  = PTR_W'((int'(rr_ptr_q) + k) % NUM_CHANNELS);
            end
        end
        if (host_elig && (!last_host_q || !ch_found)) begin
            grant_valid = 1'b1;
            grant_host  = 1'b1;
            grant_we    = host_we;
            grant_id    = ID_W'(HOST_ID);
            grant_addr  = host_addr;
            grant_wdata = host_wdata;
        end else if (ch_found) begin
            grant_valid = 1'b1;
            grant_we    = ch_write_valid[ch_pick];
            grant_id    = ID_W'(ch_pick);
            grant_addr  = grant_we ? ch_write_address[ch_pick*ADDR_BITS +: ADDR_BITS]
                                   : ch_read_address[ch_pick*ADDR_BITS +: ADDR_BITS];
            grant_wdata = ch_write_data[ch_pick*DATA_BITS +: DATA_BITS];
        end
    end

    // Next values for the RAM command, arbitration history and pipeline head.
    always_comb begin
        rr_ptr_d    = (grant_valid && !grant_host) ? ch_pick : rr_ptr_q;
        last_host_d = grant_valid ? grant_host : last_host_q;
        mem_en_d    = grant_valid;
        mem_we_d    = grant_valid && grant_we;
        mem_addr_d  = grant_valid ? grant_addr : mem_addr_q;
        mem_wdata_d = grant_valid ? grant_wdata : mem_wdata_q;
        s1_d.valid    = grant_valid;
        s1_d.is_write = grant_we;
        s1_d.id       = grant_id;
    end

    // Per-requester FSM: IDLE -> PENDING on grant -> DONE on completion -> IDLE on request drop.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            state_d[r] = state_q[r];
            we_d[r]    = we_q[r];
            case (state_q[r])
                REQ_IDLE: begin
                    if (grant_valid && (grant_id == ID_W'(r))) begin
                        state_d[r] = REQ_PENDING;
                        we_d[r]    = grant_we;
                    end
                end
                REQ_PENDING: begin
                    // Writes finish one stage into the pipeline; reads wait for RAM data.
                    if ((s1_q.valid && s1_q.is_write && (s1_q.id == ID_W'(r))) ||
                        (s2_q.valid && !s2_q.is_write && (s2_q.id == ID_W'(r)))) begin
                        state_d[r] = REQ_DONE;
                    end
                end
                REQ_DONE: begin
                    if (!req_hold[r]) begin
                        state_d[r] = REQ_IDLE;
                    end
                end
                default: state_d[r] = REQ_IDLE;
            endcase
        end
    end

    // State, arbitration history, RAM command and in-flight pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                state_q[r] <= REQ_IDLE;
                we_q[r]    <= 1'b0;
            end
            rr_ptr_q    <= PTR_W'(NUM_CHANNELS - 1);
            last_host_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                state_q[r] <= state_d[r];
                we_q[r]    <= we_d[r];
            end
            rr_ptr_q    <= rr_ptr_d;
            last_host_q <= last_host_d;
            s1_q        <= s1_d;
            s2_q        <= s1_q;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Read data capture: RAM data for the read in the second pipeline stage.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: these few data registers are reset because their cleared value is visible on the ports.
        if (reset) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                rdata_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (s2_q.valid && !s2_q.is_write && (s2_q.id == ID_W'(r))) begin
                    rdata_q[r] <= mem_rdata;
                end
            end
        end
    end

    // Output mapping: ready/ack reflect DONE for the latched access kind.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_read_ready[i]                          = (state_q[i] == REQ_DONE) && !we_q[i];
            ch_write_ready[i]                         = (state_q[i] == REQ_DONE) && we_q[i];
            ch_read_data[i*DATA_BITS +: DATA_BITS]    = rdata_q[i];
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            busy = busy || (state_q[r] != REQ_IDLE);
        end
        host_ack   = (state_q[HOST_ID] == REQ_DONE);
        host_rdata = rdata_q[HOST_ID];
        mem_en     = mem_en_q;
        mem_we     = mem_we_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
    end

endmodule
